// File: rtl/updi_rx.sv
// updi_rx: receiver for the single-wire UPDI line.
// Deserializes 8E2 frames (start, 8 data LSB-first, even parity, 2 stop) and
// pushes good bytes into the input FIFO; flags parity/framing errors,
// FIFO overflow and BREAK.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   rx             raw UPDI line (idle high), asynchronous to clk
//   rx_en          receive enable; 0 while the transmitter owns the line
//   busy           high whenever the receiver is not idle
//   parity_error   one-cycle pulse: parity bit does not give even parity
//   frame_error    one-cycle pulse: stop bit sampled low (not a BREAK)
//   overflow       one-cycle pulse: good byte dropped, FIFO full
//   break_detected one-cycle pulse when a BREAK ends
//   out_fifo_data  received byte
//   out_fifo_full  FIFO full, looked at only when storing
//   out_fifo_wr_en one-cycle FIFO write strobe
module updi_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_en,
    output logic       busy,
    output logic       parity_error,
    output logic       frame_error,
    output logic       overflow,
    output logic       break_detected,
    output logic [7:0] out_fifo_data,
    input  logic       out_fifo_full,
    output logic       out_fifo_wr_en
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_STORE,
        S_ERR,
        S_BREAK
    } state_t;

    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_prev;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_data;
    logic             r_par_ok;
    logic             r_par_bit;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       w_data_nxt;
    logic             w_par_ok_nxt;
    logic             w_par_bit_nxt;
    logic             w_bit_tick;

    // Two-flop synchronizer plus one delay flop for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_par_ok  <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_data    <= w_data_nxt;
            r_par_ok  <= w_par_ok_nxt;
            r_par_bit <= w_par_bit_nxt;
        end
    end

    assign w_bit_tick = (r_cnt == CNT_BIT_LAST);

    // Next-state, datapath updates and state-decoded strobes
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + CNT_W'(1);
        w_idx_nxt      = r_idx;
        w_data_nxt     = r_data;
        w_par_ok_nxt   = r_par_ok;
        w_par_bit_nxt  = r_par_bit;
        parity_error   = 1'b0;
        frame_error    = 1'b0;
        overflow       = 1'b0;
        break_detected = 1'b0;
        out_fifo_wr_en = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (rx_en && r_rx_prev && !r_rx_s) begin
                    w_state_nxt = S_START;
                    w_idx_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    w_cnt_nxt  = '0;
                    w_data_nxt = {r_rx_s, r_data[7:1]};
                    w_idx_nxt  = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_cnt_nxt     = '0;
                    w_par_bit_nxt = r_rx_s;
                    w_par_ok_nxt  = ~(^r_data ^ r_rx_s);
                    w_state_nxt   = S_STOP1;
                end
            end
            S_STOP1: begin
                if (w_bit_tick) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_state_nxt = S_STOP2;
                    end else if (r_data == 8'h00 && !r_par_bit) begin
                        // All-zero frame running into the stop bit is a BREAK
                        w_state_nxt = S_BREAK;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_STOP2: begin
                if (w_bit_tick) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_rx_s ? S_STORE : S_ERR;
                end
            end
            S_STORE: begin
                w_cnt_nxt      = '0;
                parity_error   = !r_par_ok;
                overflow       = r_par_ok && out_fifo_full;
                out_fifo_wr_en = r_par_ok && !out_fifo_full;
                w_state_nxt    = S_IDLE;
            end
            S_ERR: begin
                w_cnt_nxt   = '0;
                frame_error = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (r_rx_s) begin
                    break_detected = 1'b1;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Disable aborts any frame and suppresses every strobe
        if (!rx_en) begin
            w_state_nxt    = S_IDLE;
            w_cnt_nxt      = '0;
            parity_error   = 1'b0;
            frame_error    = 1'b0;
            overflow       = 1'b0;
            break_detected = 1'b0;
            out_fifo_wr_en = 1'b0;
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign out_fifo_data = r_data;

endmodule
